cache_line_memory: RTL and testbench

Behavioural main-memory responder serving the 256-bit line interface driven by the 2-way set-associative cache. Accepts line fills (`mem_read`) and dirty-line writebacks (`mem_write`), holds the line store, and answers with a single-cycle `mem_ready` after a programmable latency. It sits directly below the cache in the cache-system testbench and FPGA demo, and closes the memory side of that interface.

---
 rtl/cache_line_memory.sv | 192 +++++++++++++++++++
 tb/tb_cache_line_memory.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_memory.sv
// cache_line_memory
//
// Behavioural main-memory responder for the 256-bit cache line interface.
// It accepts one fill (mem_read) or writeback (mem_write) at a time. It answers
// each one with a single-cycle mem_ready pulse, LATENCY cycles after the request
// is accepted.
//
// Build option:
//   CLM_STATS_EN  when defined, rd_count/wr_count count completed transactions
//                 and saturate at 16'hFFFF; when undefined both outputs are 0.
//
// Parameters:
//   LATENCY       cycles from request acceptance to mem_ready (1..255)
//   LINE_AW       line-address width; the store holds 2**LINE_AW 32-byte lines
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   mem_addr      byte address; line index = mem_addr[5 +: LINE_AW]
//   mem_wdata     writeback line
//   mem_read      fill request, level, held until mem_ready
//   mem_write     writeback request, level, held until mem_ready
//   mem_rdata     fill line, held until the next read completes
//   mem_ready     one-cycle completion pulse
//   busy          high from acceptance through the mem_ready cycle
//   protocol_err  sticky, set when read and write are both seen while idle
//   rd_count      completed reads (saturating)
//   wr_count      completed writes (saturating)

module cache_line_memory #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned LINE_AW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_addr,
    input  logic [255:0] mem_wdata,
    input  logic         mem_read,
    input  logic         mem_write,
    output logic [255:0] mem_rdata,
    output logic         mem_ready,
    output logic         busy,
    output logic         protocol_err,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);

    localparam int unsigned LINES    = 1 << LINE_AW;
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [LINE_AW-1:0]   line_q, line_d;
    logic [255:0]         wdata_q, wdata_d;
    logic                 is_write_q, is_write_d;
    logic [255:0]         rdata_q, rdata_d;
    logic                 perr_q, perr_d;

    logic [LINE_AW-1:0]   req_line;
    logic [LINE_AW-1:0]   rd_line;
    logic                 load_rdata;
    logic                 commit;

    // Line store; not touched by reset so its contents survive a reset.
    logic [255:0]         store [LINES];

    assign req_line = mem_addr[5 +: LINE_AW];

    // Byte offset and bits above the line index are ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^(mem_addr & ~(32'(LINES - 1) << 5));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        perr_d     = perr_q;
        load_rdata = 1'b0;
        commit     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    line_d     = req_line;
                    wdata_d    = mem_wdata;
                    // Write wins when both requests are raised together.
                    is_write_d = mem_write;
                    cnt_d      = CNT_INIT;
                    if (mem_read && mem_write) begin
                        perr_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        load_rdata = !mem_write;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // Requests are not re-sampled here; the latched copy is used.
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d    = StResp;
                    load_rdata = !is_write_q;
                end
            end
            StResp: begin
                // The write commits on the edge leaving RESP, so any later
                // read load already sees the new line.
                commit  = is_write_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // With LATENCY=1 the read loads straight from the incoming address.
    assign rd_line = (state_q == StIdle) ? req_line : line_q;
    assign rdata_d = load_rdata ? store[rd_line] : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            line_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
            perr_q     <= perr_d;
        end
    end

    // commit derives from the async-reset state, so a write caught by reset
    // never reaches the store.
    always_ff @(posedge clk) begin
        if (commit) begin
            store[line_q] <= wdata_q;
        end
    end

    assign mem_rdata    = rdata_q;
    assign mem_ready    = (state_q == StResp);
    assign busy         = (state_q != StIdle);
    assign protocol_err = perr_q;

`ifdef CLM_STATS_EN
    logic [15:0] rd_count_q, wr_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == StResp) begin
            if (is_write_q) begin
                if (wr_count_q != 16'hFFFF) begin
                    wr_count_q <= wr_count_q + 16'd1;
                end
            end else begin
                if (rd_count_q != 16'hFFFF) begin
                    rd_count_q <= rd_count_q + 16'd1;
                end
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_cache_line_memory.sv
// Testbench for cache_line_memory: directed scenarios plus a randomized
// transaction stream checked against a line-array reference model.

module tb_cache_line_memory;

    localparam int LAT = 4;

    logic         clk;
    logic         rst_n;

    logic [31:0]  a_addr;
    logic [255:0] a_wdata;
    logic         a_read, a_write;
    logic [255:0] a_rdata;
    logic         a_ready, a_busy, a_perr;
    logic [15:0]  a_rd_count, a_wr_count;

    logic [31:0]  b_addr;
    logic [255:0] b_wdata;
    logic         b_read, b_write;
    logic [255:0] b_rdata;
    logic         b_ready, b_busy, b_perr;
    logic [15:0]  b_rd_count, b_wr_count;

    cache_line_memory #(.LATENCY(LAT), .LINE_AW(8)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (a_addr),
        .mem_wdata    (a_wdata),
        .mem_read     (a_read),
        .mem_write    (a_write),
        .mem_rdata    (a_rdata),
        .mem_ready    (a_ready),
        .busy         (a_busy),
        .protocol_err (a_perr),
        .rd_count     (a_rd_count),
        .wr_count     (a_wr_count)
    );

    cache_line_memory #(.LATENCY(1), .LINE_AW(8)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (b_addr),
        .mem_wdata    (b_wdata),
        .mem_read     (b_read),
        .mem_write    (b_write),
        .mem_rdata    (b_rdata),
        .mem_ready    (b_ready),
        .busy         (b_busy),
        .protocol_err (b_perr),
        .rd_count     (b_rd_count),
        .wr_count     (b_wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one entry per line, zero at time 0.
    logic [255:0] model [256];
    logic [255:0] exp_rdata;
    int           rd_n, wr_n;

    task automatic check_i(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic check_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    function automatic int exp_cnt(input int n);
`ifdef CLM_STATS_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0 * n;
`endif
    endfunction

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> 5) % 256);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs one transaction on dut_a starting at the current negedge and
    // returns at the negedge of its mem_ready cycle with requests dropped.
    // hold>0 drops the request early after that many cycles.
    task automatic txn(input bit wr, input bit both, input logic [31:0] addr,
                       input logic [255:0] data, input int hold, output int rcyc);
        int k;
        int exp_lat;
        int ln;
        // A request raised during RESP waits one cycle to be accepted.
        exp_lat = a_busy ? LAT + 1 : LAT;
        a_addr  = addr;
        a_wdata = data;
        a_write = wr | both;
        a_read  = ~wr | both;
        k = 0;
        while (k < LAT + 8) begin
            @(negedge clk);
            k++;
            if (a_ready) break;
            if (k == hold) begin
                a_read  = 1'b0;
                a_write = 1'b0;
            end
        end
        check_i("ready_latency", k, exp_lat);
        check_i("busy_in_ready", int'(a_busy), 1);
        ln = line_of(addr);
        if (wr | both) begin
            model[ln] = data;
            wr_n++;
            check_w("rdata_kept_on_write", a_rdata, exp_rdata);
        end else begin
            exp_rdata = model[ln];
            rd_n++;
            check_w("rdata_fill", a_rdata, exp_rdata);
        end
        a_read  = 1'b0;
        a_write = 1'b0;
        rcyc    = cyc;
    endtask

    initial begin
        int           r1, r2, k;
        logic [255:0] d_a5, d_b, d_c, d_e, d_x;

        for (int i = 0; i < 256; i++) model[i] = '0;
        exp_rdata = '0;
        rd_n = 0;
        wr_n = 0;
        d_a5 = {32{8'hA5}};
        d_b  = rand_line();
        d_c  = rand_line();
        d_e  = rand_line();
        d_x  = rand_line();

        rst_n   = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        a_read  = 1'b0;
        a_write = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        b_read  = 1'b0;
        b_write = 1'b0;
        idle(3);
        rst_n = 1'b1;

        // Reset state.
        check_i("rst_ready", int'(a_ready), 0);
        check_i("rst_busy", int'(a_busy), 0);
        check_w("rst_rdata", a_rdata, '0);
        check_i("rst_perr", int'(a_perr), 0);
        check_i("rst_rd_count", int'(a_rd_count), 0);
        check_i("rst_wr_count", int'(a_wr_count), 0);

        // First fill of an untouched line.
        txn(1'b0, 1'b0, 32'h0000_0040, '0, 0, r1);
        @(negedge clk);
        check_i("ready_one_cycle", int'(a_ready), 0);
        check_i("busy_cleared", int'(a_busy), 0);

        // Write then read back-to-back; rdata must be held afterwards.
        txn(1'b1, 1'b0, 32'h0000_0100, d_a5, 0, r1);
        txn(1'b0, 1'b0, 32'h0000_0100, '0, 0, r2);
        idle(2);
        check_w("rdata_hold", a_rdata, d_a5);

        // Writeback to an aliasing address, then fill of line 0.
        txn(1'b1, 1'b0, 32'h0000_2000, d_e, 0, r1);
        txn(1'b0, 1'b0, 32'h0000_0000, '0, 0, r2);
        check_i("b2b_spacing", r2 - r1, LAT + 1);
        check_w("alias_fill", a_rdata, d_e);

        // Give line 0x40 known contents, then reset during a later write.
        idle(1);
        txn(1'b1, 1'b0, 32'h0000_0040, d_b, 0, r1);
        idle(1);
        a_addr  = 32'h0000_0040;
        a_wdata = d_x;
        a_write = 1'b1;
        idle(2);
        check_i("busy_wait", int'(a_busy), 1);
        rst_n   = 1'b0;
        a_write = 1'b0;
        rd_n    = 0;
        wr_n    = 0;
        exp_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_i("no_ready_in_reset", int'(a_ready), 0);
        end
        check_i("midrst_busy", int'(a_busy), 0);
        check_w("midrst_rdata", a_rdata, '0);
        rst_n = 1'b1;
        idle(1);
        check_i("midrst_rd_count", int'(a_rd_count), 0);
        check_i("midrst_wr_count", int'(a_wr_count), 0);
        txn(1'b0, 1'b0, 32'h0000_0040, '0, 0, r1);
        check_w("midrst_old_data", a_rdata, d_b);

        // Both requests high: write wins and protocol_err sticks.
        check_i("perr_before", int'(a_perr), 0);
        idle(1);
        txn(1'b0, 1'b1, 32'h0000_0080, d_c, 0, r1);
        check_i("perr_set", int'(a_perr), 1);
        idle(1);
        txn(1'b0, 1'b0, 32'h0000_0080, '0, 0, r1);
        check_w("both_wrote", a_rdata, d_c);
        idle(2);
        check_i("rd_count_dir", int'(a_rd_count), exp_cnt(rd_n));
        check_i("wr_count_dir", int'(a_wr_count), exp_cnt(wr_n));

        // Randomized stream over a few lines with aliased upper bits.
        for (int i = 0; i < 40; i++) begin
            bit           wr;
            logic [31:0]  ad;
            int           h;
            wr = 1'($urandom_range(0, 1));
            ad = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 7)) << 5)
                 | ($urandom & 32'h1F);
            h  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT - 1) : 0;
            if (h > 0) idle(1);
            else idle($urandom_range(0, 2));
            txn(wr, 1'b0, ad, rand_line(), h, r1);
        end
        idle(2);
        check_i("perr_sticky", int'(a_perr), 1);
        check_i("rd_count_rand", int'(a_rd_count), exp_cnt(rd_n));
        check_i("wr_count_rand", int'(a_wr_count), exp_cnt(wr_n));

        // LATENCY=1 instance: write, one idle cycle, then read back.
        b_addr  = 32'h0000_0060;
        b_wdata = d_e;
        b_write = 1'b1;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            k++;
            if (b_ready) break;
        end
        check_i("lat1_write_latency", k, 1);
        b_write = 1'b0;
        idle(1);
        b_read = 1'b1;
        k = 0;
        while (k < 8) begin
            @(negedge clk);
            k++;
            if (b_ready) break;
        end
        check_i("lat1_read_latency", k, 1);
        check_w("lat1_read_data", b_rdata, d_e);
        b_read = 1'b0;
        idle(1);
        check_i("lat1_busy_cleared", int'(b_busy), 0);
        check_i("lat1_perr", int'(b_perr), 0);
        check_i("lat1_rd_count", int'(b_rd_count), exp_cnt(1));
        check_i("lat1_wr_count", int'(b_wr_count), exp_cnt(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
